// File: rtl/alu_dispatch.sv
// Issue sequencer for the fixed-point ALU: one operation in flight, illegal-opcode
// rejection and a watchdog so a hung multiply/divide always produces an error response.
module alu_dispatch #(
   parameter int N       = 32,
   parameter int Q       = 16,
   parameter int TIMEOUT = 64,
   parameter int TAG_W   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [3:0]              req_opcode,
   input  logic signed [N-1:0]     req_a,
   input  logic signed [N-1:0]     req_b,
   input  logic signed [N-1:0]     req_imm,
   input  logic [TAG_W-1:0]        req_tag,
   output logic                    enable_alu,
   output logic [3:0]              opcode,
   output logic signed [N-1:0]     dataA,
   output logic signed [N-1:0]     dataB,
   output logic signed [N-1:0]     data_imm,
   input  logic                    valid,
   input  logic                    zero,
   input  logic [N-1:0]            data_out,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [N-1:0]            rsp_data,
   output logic                    rsp_zero,
   output logic [TAG_W-1:0]        rsp_tag,
   output logic                    rsp_error
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   // Q only describes the operand format; reject nonsensical combinations at elaboration.
   if (Q >= N || TIMEOUT < 2) begin : g_bad_params
      $error("alu_dispatch: Q must be below N and TIMEOUT at least 2");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state_reg;
   logic [CW-1:0]      count_reg;
   logic [TAG_W-1:0]   tag_reg;
   logic               enable_alu_reg;
   logic [3:0]         opcode_reg;
   logic [N-1:0]       a_reg;
   logic [N-1:0]       b_reg;
   logic [N-1:0]       imm_reg;
   logic               rsp_valid_reg;
   logic [N-1:0]       rsp_data_reg;
   logic               rsp_zero_reg;
   logic [TAG_W-1:0]   rsp_tag_reg;
   logic               rsp_error_reg;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011,
         4'b0101, 4'b0110, 4'b0111, 4'b1000: is_legal = 1'b1;
         default:                            is_legal = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         count_reg      <= '0;
         tag_reg        <= '0;
         enable_alu_reg <= 1'b0;
         opcode_reg     <= '0;
         a_reg          <= '0;
         b_reg          <= '0;
         imm_reg        <= '0;
         rsp_valid_reg  <= 1'b0;
         rsp_data_reg   <= '0;
         rsp_zero_reg   <= 1'b0;
         rsp_tag_reg    <= '0;
         rsp_error_reg  <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (req_valid) begin
                  tag_reg   <= req_tag;
                  count_reg <= '0;
                  if (is_legal(req_opcode)) begin
                     enable_alu_reg <= 1'b1;
                     opcode_reg     <= req_opcode;
                     a_reg          <= req_a;
                     b_reg          <= req_b;
                     imm_reg        <= req_imm;
                     state_reg      <= S_EXEC;
                  end else begin
                     rsp_valid_reg <= 1'b1;
                     rsp_error_reg <= 1'b1;
                     rsp_data_reg  <= '0;
                     rsp_zero_reg  <= 1'b0;
                     rsp_tag_reg   <= req_tag;
                     state_reg     <= S_RESP;
                  end
               end
            end
            S_EXEC: begin
               // A result arriving on the last watchdog cycle still counts as success.
               if (valid || count_reg == LAST_CNT) begin
                  enable_alu_reg <= 1'b0;
                  opcode_reg     <= '0;
                  a_reg          <= '0;
                  b_reg          <= '0;
                  imm_reg        <= '0;
                  rsp_valid_reg  <= 1'b1;
                  rsp_tag_reg    <= tag_reg;
                  rsp_error_reg  <= ~valid;
                  rsp_data_reg   <= valid ? data_out : '0;
                  rsp_zero_reg   <= valid & zero;
                  state_reg      <= S_RESP;
               end else begin
                  count_reg <= count_reg + 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = (state_reg == S_IDLE) && !rst;
   assign enable_alu = enable_alu_reg;
   assign opcode     = opcode_reg;
   assign dataA      = a_reg;
   assign dataB      = b_reg;
   assign data_imm   = imm_reg;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_data   = rsp_data_reg;
   assign rsp_zero   = rsp_zero_reg;
   assign rsp_tag    = rsp_tag_reg;
   assign rsp_error  = rsp_error_reg;

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Issue-side sequencer for the fixed-point `alu`: accepts one operation at a time over a valid/ready request channel and drives `enable_alu`, `opcode` and the operands into the ALU. It holds the ALU inputs stable until the ALU raises `valid`, then captures `data_out`/`zero` and returns them on a valid/ready response channel. It adds illegal-opcode rejection and a watchdog timeout, so a hung multi-cycle unit (multiply/divide) cannot stall the datapath.

## Interface
- `N`, 32, datapath width; must match the ALU.
- `Q`, 16, fractional bits; carried for integration consistency, no arithmetic use here.
- `TIMEOUT`, 64, maximum EXEC cycles waiting for ALU `valid`; must be ≥ 2.
- `TAG_W`, 4, request tag width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  dispatcher can accept a request.
- `req_opcode`  in  4  ALU opcode.
- `req_a`, `req_b`, `req_imm`  in  N each  operands, signed.
- `req_tag`  in  TAG_W  returned unchanged with the response.
- `enable_alu`  out  1  ALU enable, held for the whole operation.
- `opcode`  out  4  to ALU.
- `dataA`, `dataB`, `data_imm`  out  N each  to ALU.
- `valid`  in  1  ALU result valid.
- `zero`  in  1  ALU zero flag.
- `data_out`  in  N  ALU result.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  N  captured result; 0 on error.
- `rsp_zero`  out  1  captured zero flag; 0 on error.
- `rsp_tag`  out  TAG_W  tag of the request.
- `rsp_error`  out  1  1 = illegal opcode or timeout.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid & req_ready`, register opcode, operands and tag.
  - Legal opcodes are 0000, 0001, 0010, 0011, 0101, 0110, 0111 and 1000. A legal opcode goes to EXEC; any other opcode goes to RESP with `rsp_error`=1, `rsp_data`=0, `rsp_zero`=0, and `enable_alu` never asserts.
- **EXEC**
  - `enable_alu`=1; `opcode`/`dataA`/`dataB`/`data_imm` driven from the registers and held constant every EXEC cycle.
  - The timeout counter clears on EXEC entry and increments each EXEC cycle.
  - On the first cycle with `valid`=1: capture `data_out`→`rsp_data` and `zero`→`rsp_zero`, set `rsp_error`=0, go to RESP.
  - If `valid`=1 and the counter reaches `TIMEOUT`-1 in the same cycle, the valid result wins.
  - Counter reaches `TIMEOUT`-1 with `valid`=0: go to RESP with `rsp_error`=1, data 0, zero 0.
- **RESP**
  - `enable_alu`=0 and `rsp_valid`=1.
  - `rsp_*` are held stable until `rsp_ready`=1, then go to IDLE.
  - `rsp_ready` is ignored when `rsp_valid`=0.
- Outside EXEC, `enable_alu`=0 and `opcode`/`dataA`/`dataB`/`data_imm` are 0.
- ALU results pass through unmodified (Q-format interpretation belongs to the ALU).
- Integration: the ALU's `rstn` is driven by `~rst`, so the ALU resets together with the dispatcher.

## Timing
- Reset values (while `rst`=1 and the cycle after):
  - state IDLE, counter 0.
  - `req_ready`=0 while `rst`=1, then 1.
  - `enable_alu`, `opcode`, `dataA`, `dataB`, `data_imm` all 0.
  - `rsp_valid`, `rsp_data`, `rsp_zero`, `rsp_tag`, `rsp_error` all 0.
- Request accepted at edge T:
  - EXEC from T+1.
  - Single-cycle ops (0000–0011): ALU `valid` in cycle T+1; `rsp_valid` from T+2.
  - Multi-cycle ops: ALU `valid` in cycle T+L (L ≥ 1); `rsp_valid` from T+L+1.
  - Timeout: `rsp_valid`, with `rsp_error`=1, from T+TIMEOUT+1.
  - Illegal opcode: `rsp_valid` from T+1.
- Throughput: one operation in flight. After the response handshake at edge R, `req_ready`=1 from R+1. Minimum issue interval is 3 cycles for single-cycle ops.
- `rst` asserted in any state: IDLE at the next edge. Any in-flight result is discarded; no response is produced.

## Test plan
- Add: opcode 0000, A=5, B=7, tag 3 → `enable_alu` high exactly 1 cycle; `rsp_data`=12, `rsp_zero`=0, `rsp_tag`=3, `rsp_error`=0, `rsp_valid` at T+2.
- Zero flag: opcode 0000, A=3, B=−3 → `rsp_data`=0, `rsp_zero`=1. Opcode 0001, A=0x10, imm=0x20 → `rsp_data`=0x30.
- Multiply Q16.16: opcode 0101, A=0x00018000 (1.5), B=0x00020000 (2.0) → opcode/operands stable and `enable_alu` high until `valid`; `rsp_data`=0x00030000.
- Illegal opcode 1111, tag 9 → `enable_alu` never high; at T+1 `rsp_valid`=1, `rsp_error`=1, `rsp_data`=0, `rsp_tag`=9.
- Timeout with `TIMEOUT`=8, ALU model never raising `valid` → `enable_alu` high exactly 8 cycles; `rsp_error`=1 at T+9.
- Backpressure and reset:
  - Hold `rsp_ready`=0 for 5 cycles → `rsp_*` unchanged, `req_ready`=0, `enable_alu`=0.
  - Assert `rst` during EXEC of a divide → all outputs return to reset values; no response follows.
  - A new add after reset completes normally.
